phase_fifo_reader: RTL

- Read-side controller for the 4-deep trellis phase FIFO.
- Paces read strobes into the FIFO at a programmable nominal period and tracks FIFO fill by mirroring writes and reads.
- Trims the period by ±1 cycle to hold the fill near mid-depth, and captures FIFO output into a registered phase stream with a valid strobe.
- Sits between the FIFO and the trellis decoder input.

---
 rtl/phase_fifo_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/phase_fifo_reader.sv
// Read-side pacing controller for the 4-deep trellis phase FIFO: mirrors the FIFO fill,
// issues read strobes at a trimmed period and registers the phase sample handed to the decoder.
module phase_fifo_reader #(
    parameter int DEPTH       = 4,
    parameter int PRIME_LEVEL = 2,
    parameter int HIGH_MARK   = 3,
    parameter int LOW_MARK    = 1,
    parameter int PER_W       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         enIn,
    input  logic [PER_W-1:0]             rdPeriod,
    input  logic [7:0]                   phaseIn,
    output logic                         enOut,
    output logic [7:0]                   phaseOut,
    output logic                         phaseValid,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         resync,
    output logic                         running
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = PER_W + 1;

    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_PRIME = LVL_W'(PRIME_LEVEL);
    localparam logic [LVL_W-1:0] LVL_HIGH  = LVL_W'(HIGH_MARK);
    localparam logic [LVL_W-1:0] LVL_LOW   = LVL_W'(LOW_MARK);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         phase_q, phase_d;
    logic               valid_q, valid_d;
    logic               resync_q, resync_d;

    logic [CNT_W-1:0]   basePeriod;
    logic [CNT_W-1:0]   effPeriod;
    logic [LVL_W-1:0]   levelStep;

    // The period is one bit wider than rdPeriod so that a lengthened 255 becomes 256.
    always_comb begin
        basePeriod = {1'b0, rdPeriod};
        if (rdPeriod < PER_W'(2)) begin
            basePeriod = CNT_TWO;
        end
        effPeriod = basePeriod;
        if (level_q >= LVL_HIGH) begin
            if (basePeriod > CNT_TWO) begin
                effPeriod = basePeriod - CNT_ONE;
            end
        end else if (level_q <= LVL_LOW) begin
            effPeriod = basePeriod + CNT_ONE;
        end
    end

    always_comb begin
        levelStep = level_q;
        if (enIn && !enOut && (level_q != LVL_FULL)) begin
            levelStep = level_q + LVL_ONE;
        end else if (enOut && !enIn && (level_q != '0)) begin
            levelStep = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            level_q  <= '0;
            count_q  <= '0;
            phase_q  <= 8'h00;
            valid_q  <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            count_q  <= count_d;
            phase_q  <= phase_d;
            valid_q  <= valid_d;
            resync_q <= resync_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        count_d  = count_q;
        resync_d = 1'b0;
        valid_d  = enOut;
        phase_d  = enOut ? phaseIn : phase_q;

        case (state_q)
            IDLE: begin
                level_d = '0;
                count_d = '0;
                if (enable) begin
                    state_d = PRIME;
                end
            end
            default: begin
                if (!enable) begin
                    state_d = IDLE;
                    level_d = '0;
                    count_d = '0;
                end else if (enIn && !enOut && (level_q == LVL_FULL)) begin
                    // The FIFO clears itself when written while full; follow it back to priming.
                    state_d  = PRIME;
                    level_d  = '0;
                    count_d  = '0;
                    resync_d = 1'b1;
                end else begin
                    level_d = levelStep;
                    if (state_q == PRIME) begin
                        if (level_q >= LVL_PRIME) begin
                            state_d = RUN;
                            count_d = effPeriod;
                        end
                    end else if (count_q <= CNT_ONE) begin
                        if (level_q != '0) begin
                            count_d = effPeriod;
                        end else begin
                            state_d  = PRIME;
                            count_d  = '0;
                            resync_d = 1'b1;
                        end
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        enOut   = 1'b0;
        running = 1'b0;
        if (state_q == RUN) begin
            running = 1'b1;
            enOut   = enable && (count_q <= CNT_ONE) && (level_q != '0);
        end
    end

    assign level      = level_q;
    assign phaseOut   = phase_q;
    assign phaseValid = valid_q;
    assign resync     = resync_q;

endmodule
